// File: rtl/fp32_pkg.sv
// ============================================================================
// Module      : fp32_pkg
// Description : Shared IEEE-754 single-precision constants, unpacked-operand
//               type and unpack helper for the fp32 datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam logic [7:0]  BIAS    = 8'd127;
    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp32_unpacked_t;

    // Denormals report as zero: the multiplier flushes them.
    function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
        fp32_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.frac    = x[22:0];
        u.is_zero = (x[30:23] == 8'd0);
        u.is_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
        u.is_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
        return u;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_round_pack.sv
// ============================================================================
// Module      : fp32_round_pack
// Description : Combinational normalize / round-to-nearest-even / pack stage
//               for a 48-bit significand product, with special-case priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_round_pack
    import fp32_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = QNAN
) (
    input  logic [47:0]       p,
    input  logic signed [9:0] esum,
    input  logic              sign,
    input  logic              any_nan,
    input  logic              any_inf,
    input  logic              any_zero,
    output logic [31:0]       result,
    output logic              exception,
    output logic              overflow,
    output logic              underflow
);

    logic [22:0]        w_m;
    logic [22:0]        w_m_rnd;
    logic               w_g;
    logic               w_s;
    logic               w_rup;
    logic [23:0]        w_sum;
    logic signed [11:0] w_e;
    logic signed [11:0] w_e_rnd;

    always_comb begin
        w_m     = 23'd0;
        w_g     = 1'b0;
        w_s     = 1'b0;
        w_e     = {{2{esum[9]}}, esum};
        if (p[47]) begin
            w_m = p[46:24];
            w_g = p[23];
            w_s = |p[22:0];
            w_e = {{2{esum[9]}}, esum} + 12'sd1;
        end else begin
            w_m = p[45:23];
            w_g = p[22];
            w_s = |p[21:0];
        end

        w_rup   = w_g & (w_s | w_m[0]);
        w_sum   = {1'b0, w_m} + {23'd0, w_rup};
        // Mantissa rounding up past 1.111..1 renormalises to 1.0 x 2^(e+1).
        w_m_rnd = w_sum[23] ? 23'd0 : w_sum[22:0];
        w_e_rnd = w_sum[23] ? (w_e + 12'sd1) : w_e;

        result    = {sign, w_e_rnd[7:0], w_m_rnd};
        exception = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (any_nan || (any_inf && any_zero)) begin
            result    = NAN_VALUE;
            exception = 1'b1;
        end else if (any_inf) begin
            result    = {sign, 8'hFF, 23'd0};
            exception = 1'b1;
        end else if (any_zero) begin
            result    = {sign, 31'd0};
        end else if (w_e_rnd >= $signed({4'd0, EXP_MAX})) begin
            result    = {sign, 8'hFF, 23'd0};
            overflow  = 1'b1;
        end else if (w_e_rnd <= 12'sd0) begin
            result    = {sign, 31'd0};
            underflow = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp32_mul_pipeline.sv
// ============================================================================
// Module      : fp32_mul_pipeline
// Description : Three-stage IEEE-754 single-precision multiplier with
//               valid/ready handshake and global stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_mul_pipeline
    import fp32_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    fp32_unpacked_t     w_ua;
    fp32_unpacked_t     w_ub;
    logic               w_adv;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic signed [9:0]  r_s1_esum;
    logic [23:0]        r_s1_ma;
    logic [23:0]        r_s1_mb;
    logic               r_s1_nan;
    logic               r_s1_inf;
    logic               r_s1_zero;

    logic               r_s2_valid;
    logic               r_s2_sign;
    logic signed [9:0]  r_s2_esum;
    logic [47:0]        r_s2_p;
    logic               r_s2_nan;
    logic               r_s2_inf;
    logic               r_s2_zero;

    logic               r_out_valid;
    logic [31:0]        r_result;
    logic               r_exc;
    logic               r_ovf;
    logic               r_unf;

    logic [31:0]        w_result;
    logic               w_exc;
    logic               w_ovf;
    logic               w_unf;

    assign w_ua     = fp32_unpack(a);
    assign w_ub     = fp32_unpack(b);
    // Whole pipe moves together; a held output freezes every stage.
    assign w_adv    = out_ready | ~r_out_valid;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_esum  <= '0;
            r_s1_ma    <= '0;
            r_s1_mb    <= '0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_esum  <= '0;
            r_s2_p     <= '0;
            r_s2_nan   <= 1'b0;
            r_s2_inf   <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= w_ua.sign ^ w_ub.sign;
            r_s1_esum  <= $signed({2'b00, w_ua.exp} + {2'b00, w_ub.exp} - {2'b00, BIAS});
            r_s1_ma    <= {1'b1, w_ua.frac};
            r_s1_mb    <= {1'b1, w_ub.frac};
            r_s1_nan   <= w_ua.is_nan | w_ub.is_nan;
            r_s1_inf   <= w_ua.is_inf | w_ub.is_inf;
            r_s1_zero  <= w_ua.is_zero | w_ub.is_zero;

            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_esum  <= r_s1_esum;
            r_s2_p     <= {24'd0, r_s1_ma} * {24'd0, r_s1_mb};
            r_s2_nan   <= r_s1_nan;
            r_s2_inf   <= r_s1_inf;
            r_s2_zero  <= r_s1_zero;
        end
    end

    fp32_round_pack #(
        .NAN_VALUE (NAN_VALUE)
    ) u_round_pack (
        .p         (r_s2_p),
        .esum      (r_s2_esum),
        .sign      (r_s2_sign),
        .any_nan   (r_s2_nan),
        .any_inf   (r_s2_inf),
        .any_zero  (r_s2_zero),
        .result    (w_result),
        .exception (w_exc),
        .overflow  (w_ovf),
        .underflow (w_unf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_exc       <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            r_result    <= w_result;
            r_exc       <= w_exc;
            r_ovf       <= w_ovf;
            r_unf       <= w_unf;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign Exception = r_exc;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_fp32_mul_pipeline.sv
// ============================================================================
// Module      : tb_fp32_mul_pipeline
// Description : Directed scoreboard bench for the pipelined fp32 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_mul_pipeline;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;

    int          checks   = 0;
    int          failures = 0;
    logic [34:0] sb_q[$];

    fp32_mul_pipeline dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result, Exception, Overflow, Underflow compared on every output transfer.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", {29'd0, result, Exception, Overflow, Underflow}, 64'h0);
                checks--;
                checks++;
                if (result == 32'd0 && !Exception && !Overflow && !Underflow) begin
                    failures++;
                    $error("FAIL unexpected_output got=%0h exp=none", result);
                end
            end else begin
                logic [34:0] e;
                e = sb_q.pop_front();
                check("result_flags", {29'd0, result, Exception, Overflow, Underflow}, {29'd0, e});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the operands were accepted.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] er, input logic [2:0] ef);
        int n;
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $error("FAIL send_timeout got=in_ready0 exp=in_ready1");
        end else begin
            sb_q.push_back({er, ef});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic latency_check(input string tag);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, 64'(cyc), 64'd3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        #1 rst    = 1'b0;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", {29'd0, result, Exception, Overflow, Underflow}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Directed single operations
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
        latency_check("latency_first");
        drain();
        send(32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000);
        send(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
        send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000);
        send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000);
        send(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
        send(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
        send(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
        send(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b100);
        send(32'h00000001, 32'h40000000, 32'h00000000, 3'b000);
        send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
        drain();

        // Stream five, then stall with op3 parked at the output
        send(32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
        send(32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000);
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
        send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000);
        send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_result", {32'd0, result}, 64'h40100000);
        end
        check("stall_pending", 64'(sb_q.size()), 64'd3);
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight
        send(32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
        send(32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000);
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
        rst = 1'b0;
        #1;
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_result", {29'd0, result, Exception, Overflow, Underflow}, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle", {63'd0, out_valid}, 64'd0);
        end
        send(32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000);
        latency_check("latency_after_reset");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
